// File: rtl/serial_mag_comparator.sv
// -----------------------------------------------------------------------------
// serial_mag_comparator
//
// Purpose:
//   Sequential magnitude comparator. Two operands A and B arrive as serial bit
//   streams on x and y, one bit pair per cycle in which bit_valid is high.
//   After WIDTH bit pairs have been consumed, a registered gt/eq/lt verdict is
//   produced together with a one-cycle done pulse. The verdict and bit count
//   are held until the next accepted start.
//
//   Default stream order is MSB-first: the first differing bit pair decides
//   the relation, and the relation is locked for the rest of the word.
//
//   Optional feature (compile-time macro SERIAL_CMP_LSB_FIRST_EN):
//     defined   -> streams are LSB-first. Every differing bit pair overwrites
//                  the relation, so the last (most significant) difference
//                  wins. Timing, ports and everything else are unchanged.
//     undefined -> MSB-first lock-on-first-difference (default build).
//
// Parameters:
//   WIDTH  number of bit pairs per comparison (>= 1)
//   CW     derived width of bit_count, $clog2(WIDTH+1) (not overridable)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin a new comparison (honoured only in IDLE)
//   bit_valid  in   x/y carry a valid bit pair this cycle (used only in RUN)
//   x          in   serial operand A bit
//   y          in   serial operand B bit
//   busy       out  high while a comparison is running
//   done       out  one-cycle pulse, verdict valid
//   gt/eq/lt   out  registered verdict A>B / A==B / A<B, held until next start
//   bit_count  out  bit pairs consumed in the current or last comparison
// -----------------------------------------------------------------------------
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         bit_valid,
    input  logic                         x,
    input  logic                         y,
    output logic                         busy,
    output logic                         done,
    output logic                         gt,
    output logic                         eq,
    output logic                         lt,
    output logic [$clog2(WIDTH+1)-1:0]   bit_count
);

    localparam int CW = $clog2(WIDTH + 1);

    // Count value seen just before the last bit pair is consumed, and the
    // terminal count loaded when the word completes.
    localparam logic [CW-1:0] LAST_IDX  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REL_EQUAL   = 2'd0,
        REL_GREATER = 2'd1,
        REL_LESS    = 2'd2
    } rel_t;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_t          state_q, state_d;
    rel_t            rel_q, rel_d;
    logic [CW-1:0]   bit_count_q, bit_count_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            gt_q, gt_d;
    logic            eq_q, eq_d;
    logic            lt_q, lt_d;

    // Relation after folding in the current x/y pair (only used when a bit
    // is actually consumed in RUN).
    rel_t            rel_upd;
    logic            last_bit;

    // -------------------------------------------------------------------------
    // Per-bit relation update
    // -------------------------------------------------------------------------
    always_comb begin
        rel_upd = rel_q;
`ifdef SERIAL_CMP_LSB_FIRST_EN
        // LSB-first: later bits are more significant, so any difference
        // overrides whatever was decided before.
        if (x != y) begin
            rel_upd = x ? REL_GREATER : REL_LESS;
        end
`else
        // MSB-first: the first difference is the most significant one; once
        // the relation has left EQUAL it must not change again.
        if ((rel_q == REL_EQUAL) && (x != y)) begin
            rel_upd = x ? REL_GREATER : REL_LESS;
        end
`endif
    end

    assign last_bit = (bit_count_q == LAST_IDX);

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rel_d       = rel_q;
        bit_count_d = bit_count_q;
        gt_d        = gt_q;
        eq_d        = eq_q;
        lt_d        = lt_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // bit_valid/x/y are deliberately not looked at here so that
                // stray bits outside RUN can never influence a verdict.
                if (start) begin
                    state_d     = ST_RUN;
                    busy_d      = 1'b1;
                    bit_count_d = '0;
                    rel_d       = REL_EQUAL;
                    gt_d        = 1'b0;
                    eq_d        = 1'b0;
                    lt_d        = 1'b0;
                end
            end

            ST_RUN: begin
                busy_d = 1'b1;
                // start is ignored here: a comparison cannot be restarted.
                if (bit_valid) begin
                    rel_d       = rel_upd;
                    bit_count_d = bit_count_q + CW'(1);
                    if (last_bit) begin
                        // Final pair: publish the verdict on the same edge
                        // so it appears together with done.
                        state_d     = ST_DONE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        bit_count_d = FULL_CNT;
                        gt_d        = (rel_upd == REL_GREATER);
                        eq_d        = (rel_upd == REL_EQUAL);
                        lt_d        = (rel_upd == REL_LESS);
                    end
                end
            end

            ST_DONE: begin
                // Single-cycle state; done_d/busy_d default low so the
                // pulse ends on this edge.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rel_q       <= REL_EQUAL;
            bit_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            gt_q        <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rel_q       <= rel_d;
            bit_count_q <= bit_count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            gt_q        <= gt_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign gt        = gt_q;
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// -----------------------------------------------------------------------------
// tb_serial_mag_comparator
//
// Directed and randomized bench for serial_mag_comparator (WIDTH=8). Operands
// are streamed in the order selected by SERIAL_CMP_LSB_FIRST_EN; the expected
// verdict is plain numeric comparison of the two 8-bit operands.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_mag_comparator;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          bit_valid;
    logic          x;
    logic          y;
    logic          busy;
    logic          done;
    logic          gt;
    logic          eq;
    logic          lt;
    logic [CW-1:0] bit_count;

    int tests = 0;
    int fails = 0;

    // Stall cycles inserted after bit index i (i = 0..W-2) and whether start
    // is pulsed during those stalls.
    int stalls [W];
    bit start_in_stall;

    serial_mag_comparator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .x         (x),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .gt        (gt),
        .eq        (eq),
        .lt        (lt),
        .bit_count (bit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Bit of operand v presented at stream step i.
    function automatic logic bit_at(input logic [W-1:0] v, input int i);
`ifdef SERIAL_CMP_LSB_FIRST_EN
        return v[i];
`else
        return v[W-1-i];
`endif
    endfunction

    task automatic chk_verdict(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        chk({tag, ".gt"}, 32'(gt), 32'(a > b));
        chk({tag, ".eq"}, 32'(eq), 32'(a == b));
        chk({tag, ".lt"}, 32'(lt), 32'(a < b));
        chk({tag, ".cnt"}, 32'(bit_count), 32'(W));
    endtask

    task automatic clear_stalls();
        for (int k = 0; k < W; k++) stalls[k] = 0;
        start_in_stall = 1'b0;
    endtask

    // One full comparison; called at a falling edge with the DUT in IDLE.
    task automatic do_compare(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        int waited;
        int exp_wait;
        exp_wait = W;
        for (int k = 0; k < W - 1; k++) exp_wait += stalls[k];

        @(negedge clk);
        start     = 1'b1;
        bit_valid = 1'($urandom);   // ignored in IDLE
        x         = 1'($urandom);
        y         = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
        chk({name, ".start_busy"}, 32'(busy), 32'd1);
        chk({name, ".start_done"}, 32'(done), 32'd0);
        chk({name, ".start_cnt"}, 32'(bit_count), 32'd0);
        chk({name, ".start_clr"}, {29'd0, gt, eq, lt}, 32'd0);

        waited = 0;
        for (int i = 0; i < W; i++) begin
            bit_valid = 1'b1;
            x         = bit_at(a, i);
            y         = bit_at(b, i);
            @(negedge clk);
            waited++;
            if (i < W - 1) begin
                chk({name, ".run_busy"}, 32'(busy), 32'd1);
                chk({name, ".run_done"}, 32'(done), 32'd0);
                chk({name, ".run_cnt"}, 32'(bit_count), 32'(i + 1));
                for (int s = 0; s < stalls[i]; s++) begin
                    bit_valid = 1'b0;
                    x         = 1'($urandom);
                    y         = 1'($urandom);
                    start     = start_in_stall;
                    @(negedge clk);
                    waited++;
                    start = 1'b0;
                    chk({name, ".stall_busy"}, 32'(busy), 32'd1);
                    chk({name, ".stall_cnt"}, 32'(bit_count), 32'(i + 1));
                end
            end
        end
        bit_valid = 1'b0;
        chk({name, ".done"}, 32'(done), 32'd1);
        chk({name, ".done_busy"}, 32'(busy), 32'd0);
        chk({name, ".latency"}, 32'(waited), 32'(exp_wait));
        chk_verdict(name, a, b);
        $display("[TB] %s a=%02h b=%02h gt=%0b eq=%0b lt=%0b cnt=%0d cycles=%0d",
                 name, a, b, gt, eq, lt, bit_count, waited);

        @(negedge clk);
        chk({name, ".done_fall"}, 32'(done), 32'd0);
        chk({name, ".idle_busy"}, 32'(busy), 32'd0);
        chk_verdict({name, ".held"}, a, b);
    endtask

    // Idle cycles with random junk on the bit inputs; verdict must hold.
    task automatic hold_idle(input int n, input logic [W-1:0] a, input logic [W-1:0] b);
        for (int c = 0; c < n; c++) begin
            bit_valid = 1'($urandom);
            x         = 1'($urandom);
            y         = 1'($urandom);
            @(negedge clk);
            chk("hold.busy", 32'(busy), 32'd0);
            chk("hold.done", 32'(done), 32'd0);
            chk_verdict("hold", a, b);
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst       = 1'b1;
        start     = 1'b0;
        bit_valid = 1'b0;
        x         = 1'b0;
        y         = 1'b0;
        clear_stalls();

        // Reset state
        #1;
        chk("reset.outs", {26'd0, busy, done, gt, eq, lt, 1'b0}, 32'd0);
        chk("reset.cnt", 32'(bit_count), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset.busy", 32'(busy), 32'd0);

        // Directed cases
        do_compare(8'hA5, 8'hA5, "eq_a5");
        do_compare(8'h80, 8'h7F, "gt_80_7f");
        do_compare(8'h3C, 8'h3D, "lt_3c_3d");
        hold_idle(5, 8'h3C, 8'h3D);

        // Stalls after bits 2 and 5, start pulsed while stalled: 14 cycles.
        clear_stalls();
        stalls[1]      = 3;
        stalls[4]      = 3;
        start_in_stall = 1'b1;
        do_compare(8'h5A, 8'h59, "stall_5a_59");
        clear_stalls();

        // Reset in the middle of a comparison, with start also high.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            x         = bit_at(8'hFF, i);
            y         = bit_at(8'h00, i);
            @(negedge clk);
        end
        chk("mid.cnt_before_rst", 32'(bit_count), 32'd4);
        rst   = 1'b1;
        start = 1'b1;
        #1;
        chk("mid_rst.outs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        chk("mid_rst.cnt", 32'(bit_count), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst.idle_busy", 32'(busy), 32'd0);
        chk("mid_rst.idle_cnt", 32'(bit_count), 32'd0);
        $display("[TB] reset mid-comparison handled");
        do_compare(8'h00, 8'hFF, "lt_00_ff");

`ifdef SERIAL_CMP_LSB_FIRST_EN
        do_compare(8'h01, 8'h02, "lsb_01_02");
        do_compare(8'h81, 8'h7F, "lsb_81_7f");
`endif

        // Randomized comparisons
        for (int t = 0; t < 25; t++) begin
            ra = W'($urandom);
            case ($urandom_range(2, 0))
                0:       rb = ra;
                1:       rb = ra ^ (W'(1) << $urandom_range(W - 1, 0));
                default: rb = W'($urandom);
            endcase
            for (int k = 0; k < W; k++)
                stalls[k] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
            start_in_stall = 1'($urandom);
            do_compare(ra, rb, $sformatf("rand%0d", t));
            hold_idle(int'($urandom_range(3, 0)), ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
